// File: rtl/traffic_light_ctrl.sv
// Intersection light sequencer with a free-running renderer animation clock.
// Optional status outputs (phase, sec_left) are built when TRAFFIC_STATUS_EN is defined.
module traffic_light_ctrl #(
    parameter int TICK_DIV    = 25000000,
    parameter int GREEN_MIN   = 4,
    parameter int GREEN_MAX   = 10,
    parameter int ALLRED_SECS = 2,
    parameter int ANIM_HALF   = 208333
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       hold,
    input  logic       ns_req,
    input  logic       ew_req,
    output logic       traffic0_color,
    output logic       traffic1_color,
    output logic       traffic2_color,
    output logic       traffic3_color,
    output logic       anim_clk
`ifdef TRAFFIC_STATUS_EN
    ,
    output logic [1:0] phase,
    output logic [7:0] sec_left
`endif
);

    localparam int PW   = $clog2(TICK_DIV);
    localparam int TMAX = (GREEN_MAX > ALLRED_SECS) ? GREEN_MAX : ALLRED_SECS;
    localparam int TW   = $clog2(TMAX + 2);
    localparam int AW   = (ANIM_HALF > 1) ? $clog2(ANIM_HALF) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T_ALLRED  = TW'(ALLRED_SECS);
    localparam logic [TW-1:0] T_GMIN    = TW'(GREEN_MIN);
    localparam logic [TW-1:0] T_GMAX    = TW'(GREEN_MAX);
    localparam logic [TW-1:0] T_SAT     = TW'(TMAX);
    localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_HALF - 1);

    typedef enum logic [1:0] {
        AR_A   = 2'd0,
        NS_GRN = 2'd1,
        AR_B   = 2'd2,
        EW_GRN = 2'd3
    } state_t;

    // Light pattern {west, south, east, north} shown while in a given state.
    function automatic logic [3:0] light_pattern(input state_t st);
        logic [3:0] pat;
        case (st)
            NS_GRN:  pat = 4'b0101;
            EW_GRN:  pat = 4'b1010;
            default: pat = 4'b0000;
        endcase
        return pat;
    endfunction

    logic [PW-1:0] prescale_r;
    logic          sec_tick_s;
    state_t        state_r;
    state_t        state_nxt_s;
    state_t        target_s;
    logic [TW-1:0] sec_timer_r;
    logic [TW-1:0] timer_nxt_s;
    logic [TW-1:0] t_s;
    logic          go_s;
    logic          legal_s;
    logic [3:0]    lights_r;
    logic [3:0]    lights_nxt_s;
    logic [AW-1:0] anim_cnt_r;
    logic          anim_r;

    assign sec_tick_s = !hold && (prescale_r == PRE_LAST);

    // One-second prescaler, frozen while hold is asserted.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            prescale_r <= '0;
        end else if (!hold) begin
            if (prescale_r >= PRE_LAST) begin
                prescale_r <= '0;
            end else begin
                prescale_r <= prescale_r + PW'(1);
            end
        end
    end

    // Phase state and seconds-in-phase register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r     <= AR_A;
            sec_timer_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            sec_timer_r <= timer_nxt_s;
        end
    end

    // Next phase: decisions are taken only on the second tick, using requests seen then.
    always_comb begin
        t_s         = sec_timer_r + TW'(1);
        go_s        = 1'b0;
        legal_s     = 1'b1;
        target_s    = AR_A;
        state_nxt_s = state_r;
        timer_nxt_s = sec_timer_r;
        case (state_r)
            AR_A: begin
                go_s     = (t_s >= T_ALLRED);
                target_s = NS_GRN;
            end
            NS_GRN: begin
                go_s     = (t_s >= T_GMAX) || ((t_s >= T_GMIN) && ew_req);
                target_s = AR_B;
            end
            AR_B: begin
                go_s     = (t_s >= T_ALLRED);
                target_s = EW_GRN;
            end
            EW_GRN: begin
                go_s     = (t_s >= T_GMAX) || ((t_s >= T_GMIN) && ns_req);
                target_s = AR_A;
            end
            default: begin
                legal_s  = 1'b0;
                go_s     = 1'b0;
                target_s = AR_A;
            end
        endcase
        if (!legal_s) begin
            state_nxt_s = AR_A;
            timer_nxt_s = '0;
        end else if (sec_tick_s) begin
            if (go_s) begin
                state_nxt_s = target_s;
                timer_nxt_s = '0;
            end else begin
                state_nxt_s = state_r;
                timer_nxt_s = (t_s > T_SAT) ? T_SAT : t_s;
            end
        end else begin
            state_nxt_s = state_r;
            timer_nxt_s = sec_timer_r;
        end
    end

    // Lights decoded from the next state so they change on the same edge as the state.
    always_comb begin
        lights_nxt_s = light_pattern(state_nxt_s);
    end

    // Registered light outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            lights_r <= 4'b0000;
        end else begin
            lights_r <= lights_nxt_s;
        end
    end

    assign traffic0_color = lights_r[0];
    assign traffic1_color = lights_r[1];
    assign traffic2_color = lights_r[2];
    assign traffic3_color = lights_r[3];

    // Animation square wave; ignores hold on purpose so the renderer never stalls.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            anim_cnt_r <= '0;
            anim_r     <= 1'b0;
        end else if (anim_cnt_r >= ANIM_LAST) begin
            anim_cnt_r <= '0;
            anim_r     <= ~anim_r;
        end else begin
            anim_cnt_r <= anim_cnt_r + AW'(1);
        end
    end

    assign anim_clk = anim_r;

`ifdef TRAFFIC_STATUS_EN
    logic [1:0] phase_r;
    logic [7:0] sec_left_r;
    logic [7:0] sec_left_nxt_s;

    // Seconds remaining until the phase limit, measured against the next-state timer.
    always_comb begin
        case (state_nxt_s)
            NS_GRN, EW_GRN: sec_left_nxt_s = 8'(GREEN_MAX) - 8'(timer_nxt_s);
            default:        sec_left_nxt_s = 8'(ALLRED_SECS) - 8'(timer_nxt_s);
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            phase_r    <= 2'd0;
            sec_left_r <= 8'(ALLRED_SECS);
        end else begin
            phase_r    <= state_nxt_s;
            sec_left_r <= sec_left_nxt_s;
        end
    end

    assign phase    = phase_r;
    assign sec_left = sec_left_r;
`endif

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: segment table, reset corner cases and random
// stimulus checked against a seconds-and-phases reference model.
module tb_traffic_light_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int GREEN_MIN   = 2;
    localparam int GREEN_MAX   = 5;
    localparam int ALLRED_SECS = 1;
    localparam int ANIM_HALF   = 3;

    localparam logic [3:0] AR = 4'b0000;
    localparam logic [3:0] NS = 4'b0101;
    localparam logic [3:0] EW = 4'b1010;

    logic clk = 1'b0;
    logic clr_n, hold, ns_req, ew_req;
    logic traffic0_color, traffic1_color, traffic2_color, traffic3_color, anim_clk;
`ifdef TRAFFIC_STATUS_EN
    logic [1:0] phase;
    logic [7:0] sec_left;
`endif

    traffic_light_ctrl #(
        .TICK_DIV(TICK_DIV), .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
        .ALLRED_SECS(ALLRED_SECS), .ANIM_HALF(ANIM_HALF)
    ) dut (
        .clk(clk), .clr_n(clr_n), .hold(hold), .ns_req(ns_req), .ew_req(ew_req),
        .traffic0_color(traffic0_color), .traffic1_color(traffic1_color),
        .traffic2_color(traffic2_color), .traffic3_color(traffic3_color),
        .anim_clk(anim_clk)
`ifdef TRAFFIC_STATUS_EN
        , .phase(phase), .sec_left(sec_left)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: phase index 0..3 in rotation order, whole seconds spent in it,
    // running-edge counts since reset release.
    int m_phase, m_secs, m_nh, m_edges;

    typedef struct {
        int         n;
        logic       h;
        logic       ns;
        logic       ew;
        logic [3:0] l;
    } seg_t;
    seg_t tbl[$];

    task automatic add(input int n, input logic h, input logic ns, input logic ew, input logic [3:0] l);
        seg_t s;
        s.n = n; s.h = h; s.ns = ns; s.ew = ew; s.l = l;
        tbl.push_back(s);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_lights(input int ph);
        if (ph == 1) return NS;
        else if (ph == 3) return EW;
        else return AR;
    endfunction

    task automatic model_edge(input logic h, input logic ns, input logic ew);
        int   t;
        logic adv;
        m_edges++;
        if (!h) begin
            m_nh++;
            if (m_nh % TICK_DIV == 0) begin
                t = m_secs + 1;
                if (m_phase == 0 || m_phase == 2) adv = (t >= ALLRED_SECS);
                else if (m_phase == 1) adv = (t >= GREEN_MAX) || (t >= GREEN_MIN && ew);
                else adv = (t >= GREEN_MAX) || (t >= GREEN_MIN && ns);
                if (adv) begin
                    m_phase = (m_phase + 1) % 4;
                    m_secs  = 0;
                end else begin
                    m_secs = t;
                end
            end
        end
    endtask

    task automatic step(input logic h, input logic ns, input logic ew, input bit use_exp, input logic [3:0] exp);
        logic [3:0] lights;
        hold = h; ns_req = ns; ew_req = ew;
        @(posedge clk);
        model_edge(h, ns, ew);
        #1;
        lights = {traffic3_color, traffic2_color, traffic1_color, traffic0_color};
        check("lights_model", {4'b0000, lights}, {4'b0000, model_lights(m_phase)});
        check("anim_clk", {7'b0, anim_clk}, {7'b0, 1'((m_edges / ANIM_HALF) % 2)});
`ifdef TRAFFIC_STATUS_EN
        check("phase", {6'b0, phase}, 8'(m_phase));
        check("sec_left", sec_left,
              8'(((m_phase % 2) == 1 ? GREEN_MAX : ALLRED_SECS) - m_secs));
`endif
        if (use_exp) check("table_lights", {4'b0000, lights}, {4'b0000, exp});
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            for (int k = 0; k < tbl[i].n; k++)
                step(tbl[i].h, tbl[i].ns, tbl[i].ew, 1'b1, tbl[i].l);
    endtask

    task automatic do_reset();
        clr_n = 1'b0; hold = 1'b0; ns_req = 1'b0; ew_req = 1'b0;
        #1;
        check("async_lights", {4'b0000, traffic3_color, traffic2_color, traffic1_color, traffic0_color}, 8'h00);
        check("async_anim", {7'b0, anim_clk}, 8'h00);
`ifdef TRAFFIC_STATUS_EN
        check("reset_phase", {6'b0, phase}, 8'h00);
        check("reset_sec_left", sec_left, 8'(ALLRED_SECS));
`endif
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        m_phase = 0; m_secs = 0; m_nh = 0; m_edges = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Each entry: samples, hold, ns_req, ew_req, lights expected after each edge.
        add(3,  1'b0, 1'b0, 1'b0, AR);
        add(20, 1'b0, 1'b0, 1'b0, NS);
        add(4,  1'b0, 1'b0, 1'b0, AR);
        add(20, 1'b0, 1'b0, 1'b0, EW);
        add(4,  1'b0, 1'b0, 1'b0, AR);
        add(8,  1'b0, 1'b0, 1'b1, NS);
        add(4,  1'b0, 1'b0, 1'b1, AR);
        add(8,  1'b0, 1'b1, 1'b0, EW);
        add(4,  1'b0, 1'b1, 1'b0, AR);
        add(2,  1'b0, 1'b0, 1'b0, NS);
        add(1,  1'b0, 1'b0, 1'b1, NS);
        add(3,  1'b0, 1'b0, 1'b0, NS);
        add(1,  1'b0, 1'b0, 1'b1, NS);
        add(13, 1'b0, 1'b0, 1'b0, NS);
        add(4,  1'b0, 1'b0, 1'b0, AR);
        add(20, 1'b0, 1'b0, 1'b1, EW);
        add(4,  1'b0, 1'b0, 1'b0, AR);
        add(5,  1'b0, 1'b0, 1'b0, NS);
        add(10, 1'b1, 1'b0, 1'b0, NS);
        add(15, 1'b0, 1'b0, 1'b0, NS);
        add(4,  1'b0, 1'b0, 1'b0, AR);
        add(10, 1'b0, 1'b0, 1'b0, EW);

        do_reset();
        run_table(0, tbl.size() - 1);

        // Mid-EW reset pulse, then the power-up timing must repeat.
        do_reset();
        run_table(0, 2);

        for (int i = 0; i < 600; i++) begin
            logic h, ns, ew;
            h  = ($urandom_range(0, 7) == 0);
            ns = ($urandom_range(0, 2) == 0);
            ew = ($urandom_range(0, 2) == 0);
            if (i == 300) do_reset();
            step(h, ns, ew, 1'b0, AR);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
